// File: rtl/game_timer_score_if.sv
// Event bundle from the snake game logic into the timer/score bookkeeping stage.
`timescale 1ns/1ps
interface game_timer_score_if;
  // Every signal is a one-cycle pulse; valid is the pulse itself and the
  // receiver is always ready, so an event is consumed in the cycle it is seen.
  logic start;
  logic eat;
  logic game_over;

  modport master (output start, output eat, output game_over);
  modport slave  (input  start, input  eat, input  game_over);
endinterface

// File: rtl/game_timer_score.sv
// Game bookkeeping: MM:SS timer, round score and best score, each shown on
// two or four active-low seven-segment digits decoded from registered BCD.
`timescale 1ns/1ps
module game_timer_score #(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int TICK_W        = 26
) (
  input  logic                clk,
  input  logic                reset,
  game_timer_score_if.slave   ev,
  output logic                running,
  output logic [6:0]          time_HEX0,
  output logic [6:0]          time_HEX1,
  output logic [6:0]          time_HEX2,
  output logic [6:0]          time_HEX3,
  output logic [6:0]          eaten_objects_HEX4,
  output logic [6:0]          eaten_objects_HEX5,
  output logic [6:0]          highscore_HEX6,
  output logic [6:0]          highscore_HEX7,
  output logic [1:0]          state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } state_t;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_SEC - 1);

  state_t            state, state_next;
  logic              enter_run, end_run;
  logic [TICK_W-1:0] tick;
  logic              sec_tick;

  logic [3:0] s_ones, s_tens, m_ones, m_tens;
  logic [3:0] s_ones_n, s_tens_n, m_ones_n, m_tens_n;
  logic       time_sat;

  logic [3:0] sc_ones, sc_tens, sc_ones_n, sc_tens_n;
  logic [3:0] hi_ones, hi_tens;
  logic       score_sat;

  // ---------------- state machine ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // game_over only has meaning inside RUN, so in IDLE/OVER start always wins.
  always_comb begin
    state_next = state;
    enter_run  = 1'b0;
    end_run    = 1'b0;
    case (state)
      IDLE, OVER: begin
        if (ev.start) begin
          state_next = RUN;
          enter_run  = 1'b1;
        end
      end
      RUN: begin
        if (ev.game_over) begin
          state_next = OVER;
          end_run    = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign running   = (state == RUN);
  assign state_dbg = state;

  // ---------------- second divider ----------------
  assign sec_tick = (state == RUN) && (tick == TICK_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                tick <= '0;
    else if (enter_run)       tick <= '0;
    else if (state == RUN) begin
      if (tick == TICK_LAST)  tick <= '0;
      else                    tick <= tick + 1'b1;
    end
  end

  // ---------------- MM:SS counter ----------------
  assign time_sat = (m_tens == 4'd9) && (m_ones == 4'd9) &&
                    (s_tens == 4'd5) && (s_ones == 4'd9);

  always_comb begin
    s_ones_n = s_ones;
    s_tens_n = s_tens;
    m_ones_n = m_ones;
    m_tens_n = m_tens;
    if (sec_tick && !time_sat) begin
      if (s_ones != 4'd9) begin
        s_ones_n = s_ones + 4'd1;
      end else begin
        s_ones_n = 4'd0;
        if (s_tens != 4'd5) begin
          s_tens_n = s_tens + 4'd1;
        end else begin
          s_tens_n = 4'd0;
          if (m_ones != 4'd9) begin
            m_ones_n = m_ones + 4'd1;
          end else begin
            m_ones_n = 4'd0;
            m_tens_n = m_tens + 4'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset || enter_run) begin
      s_ones <= 4'd0;
      s_tens <= 4'd0;
      m_ones <= 4'd0;
      m_tens <= 4'd0;
    end else begin
      s_ones <= s_ones_n;
      s_tens <= s_tens_n;
      m_ones <= m_ones_n;
      m_tens <= m_tens_n;
    end
  end

  // ---------------- score and best score ----------------
  assign score_sat = (sc_tens == 4'd9) && (sc_ones == 4'd9);

  always_comb begin
    sc_ones_n = sc_ones;
    sc_tens_n = sc_tens;
    if ((state == RUN) && ev.eat && !score_sat) begin
      if (sc_ones != 4'd9) begin
        sc_ones_n = sc_ones + 4'd1;
      end else begin
        sc_ones_n = 4'd0;
        sc_tens_n = sc_tens + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset || enter_run) begin
      sc_ones <= 4'd0;
      sc_tens <= 4'd0;
    end else begin
      sc_ones <= sc_ones_n;
      sc_tens <= sc_tens_n;
    end
  end

  // Concatenated BCD orders like the decimal value, so one compare covers
  // tens-then-ones; an eat landing on the final cycle is already included.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_ones <= 4'd0;
      hi_tens <= 4'd0;
    end else if (end_run && ({sc_tens_n, sc_ones_n} > {hi_tens, hi_ones})) begin
      hi_ones <= sc_ones_n;
      hi_tens <= sc_tens_n;
    end
  end

  // ---------------- display decode ----------------
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  assign time_HEX0          = seg7(s_ones);
  assign time_HEX1          = seg7(s_tens);
  assign time_HEX2          = seg7(m_ones);
  assign time_HEX3          = seg7(m_tens);
  assign eaten_objects_HEX4 = seg7(sc_ones);
  assign eaten_objects_HEX5 = seg7(sc_tens);
  assign highscore_HEX6     = seg7(hi_ones);
  assign highscore_HEX7     = seg7(hi_tens);

endmodule

// File: tb/tb_game_timer_score.sv
// Directed bench for game_timer_score with a 4-cycle game second.
`timescale 1ns/1ps
module tb_game_timer_score;

  logic       clk;
  logic       reset;
  logic       running;
  logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
  logic [1:0] state_dbg;
  int         n_cmp;
  int         n_err;

  game_timer_score_if ev ();

  game_timer_score #(.TICKS_PER_SEC(4), .TICK_W(26)) dut (
    .clk                (clk),
    .reset              (reset),
    .ev                 (ev.slave),
    .running            (running),
    .time_HEX0          (hex0),
    .time_HEX1          (hex1),
    .time_HEX2          (hex2),
    .time_HEX3          (hex3),
    .eaten_objects_HEX4 (hex4),
    .eaten_objects_HEX5 (hex5),
    .highscore_HEX6     (hex6),
    .highscore_HEX7     (hex7),
    .state_dbg          (state_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  function automatic logic [6:0] exp_seg(input int d);
    case (d)
      0:       exp_seg = 7'b1000000;
      1:       exp_seg = 7'b1111001;
      2:       exp_seg = 7'b0100100;
      3:       exp_seg = 7'b0110000;
      4:       exp_seg = 7'b0011001;
      5:       exp_seg = 7'b0010010;
      6:       exp_seg = 7'b0000010;
      7:       exp_seg = 7'b1111000;
      8:       exp_seg = 7'b0000000;
      9:       exp_seg = 7'b0010000;
      default: exp_seg = 7'b1111111;
    endcase
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // time mm:ss, score, highscore, running
  task automatic check_all(input string tag, input int mt, input int mo, input int st,
                           input int so, input int ct, input int co, input int ht,
                           input int ho, input logic run);
    check_val({tag, ".HEX3"}, hex3, exp_seg(mt));
    check_val({tag, ".HEX2"}, hex2, exp_seg(mo));
    check_val({tag, ".HEX1"}, hex1, exp_seg(st));
    check_val({tag, ".HEX0"}, hex0, exp_seg(so));
    check_val({tag, ".HEX5"}, hex5, exp_seg(ct));
    check_val({tag, ".HEX4"}, hex4, exp_seg(co));
    check_val({tag, ".HEX7"}, hex7, exp_seg(ht));
    check_val({tag, ".HEX6"}, hex6, exp_seg(ho));
    check_val({tag, ".running"}, {6'd0, running}, {6'd0, run});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_cmp        = 0;
    n_err        = 0;
    reset        = 1'b1;
    ev.start     = 1'b0;
    ev.eat       = 1'b0;
    ev.game_over = 1'b0;
    step(2);
    check_all("reset", 0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
    check_val("reset.state", {5'd0, state_dbg}, 7'd0);
    reset = 1'b0;
    step(1);

    // eat ignored in IDLE
    ev.eat = 1'b1; step(1); ev.eat = 1'b0; step(1);
    check_all("idle_eat", 0, 0, 0, 0, 0, 0, 0, 0, 1'b0);

    // start: first second lands exactly 4 edges after entry
    ev.start = 1'b1; step(1); ev.start = 1'b0;
    check_all("start", 0, 0, 0, 0, 0, 0, 0, 0, 1'b1);
    check_val("start.state", {5'd0, state_dbg}, 7'd1);
    step(3);
    check_val("tick3.HEX0", hex0, exp_seg(0));
    step(1);
    check_val("tick4.HEX0", hex0, exp_seg(1));

    // start during RUN at 00:05 must not clear time or tick phase
    step(16);
    check_all("t5", 0, 0, 0, 5, 0, 0, 0, 0, 1'b1);
    ev.start = 1'b1; step(1); ev.start = 1'b0;
    check_all("run_start", 0, 0, 0, 5, 0, 0, 0, 0, 1'b1);
    step(3);
    check_all("t6", 0, 0, 0, 6, 0, 0, 0, 0, 1'b1);

    // 00:59 -> 01:00 carry on a single edge
    step(215);
    check_all("t59", 0, 0, 5, 9, 0, 0, 0, 0, 1'b1);
    step(1);
    check_all("t100", 0, 1, 0, 0, 0, 0, 0, 0, 1'b1);

    // three eats then game_over; the final cycle also carries a sec_tick
    repeat (3) begin
      ev.eat = 1'b1; step(1); ev.eat = 1'b0;
    end
    check_val("eat3.HEX4", hex4, exp_seg(3));
    ev.game_over = 1'b1; step(1); ev.game_over = 1'b0;
    check_all("over1", 0, 1, 0, 1, 0, 3, 0, 3, 1'b0);
    check_val("over1.state", {5'd0, state_dbg}, 7'd2);
    step(8);
    ev.eat = 1'b1; step(1); ev.eat = 1'b0; step(1);
    check_all("over_frozen", 0, 1, 0, 1, 0, 3, 0, 3, 1'b0);

    // lower score keeps the best score
    ev.start = 1'b1; step(1); ev.start = 1'b0;
    check_all("round2", 0, 0, 0, 0, 0, 0, 0, 3, 1'b1);
    ev.eat = 1'b1; step(1); ev.eat = 1'b0;
    ev.game_over = 1'b1; step(1); ev.game_over = 1'b0;
    check_all("over2", 0, 0, 0, 0, 0, 1, 0, 3, 1'b0);

    // eat + game_over together at score 09
    ev.start = 1'b1; step(1); ev.start = 1'b0;
    repeat (9) begin
      ev.eat = 1'b1; step(1); ev.eat = 1'b0;
    end
    check_val("score9.HEX4", hex4, exp_seg(9));
    ev.eat = 1'b1; ev.game_over = 1'b1; step(1);
    ev.eat = 1'b0; ev.game_over = 1'b0;
    check_all("eat_over", 0, 0, 0, 2, 1, 0, 1, 0, 1'b0);

    // start + game_over together: in RUN game_over wins
    ev.start = 1'b1; step(1); ev.start = 1'b0;
    step(2);
    ev.start = 1'b1; ev.game_over = 1'b1; step(1);
    ev.start = 1'b0; ev.game_over = 1'b0;
    check_all("run_both", 0, 0, 0, 0, 0, 0, 1, 0, 1'b0);
    check_val("run_both.state", {5'd0, state_dbg}, 7'd2);

    // in OVER start wins
    ev.start = 1'b1; ev.game_over = 1'b1; step(1);
    ev.start = 1'b0; ev.game_over = 1'b0;
    check_all("over_both", 0, 0, 0, 0, 0, 0, 1, 0, 1'b1);

    // score saturation at 99, then run the clock to 99:59 and past it
    ev.eat = 1'b1; step(100); ev.eat = 1'b0;
    check_val("score_sat.HEX5", hex5, exp_seg(9));
    check_val("score_sat.HEX4", hex4, exp_seg(9));
    step(23895);
    check_all("t9958", 9, 9, 5, 8, 9, 9, 1, 0, 1'b1);
    step(1);
    check_all("t9959", 9, 9, 5, 9, 9, 9, 1, 0, 1'b1);
    step(32);
    check_all("t_sat", 9, 9, 5, 9, 9, 9, 1, 0, 1'b1);
    ev.game_over = 1'b1; step(1); ev.game_over = 1'b0;
    check_all("over_sat", 9, 9, 5, 9, 9, 9, 9, 9, 1'b0);

    // asynchronous reset mid-RUN clears everything before the next edge
    ev.start = 1'b1; step(1); ev.start = 1'b0;
    ev.eat = 1'b1; step(5); ev.eat = 1'b0;
    check_all("pre_reset", 0, 0, 0, 1, 0, 5, 9, 9, 1'b1);
    #2 reset = 1'b1;
    #1;
    check_all("async_reset", 0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
    check_val("async_reset.state", {5'd0, state_dbg}, 7'd0);
    step(1);
    reset = 1'b0;
    step(2);
    check_all("post_reset", 0, 0, 0, 0, 0, 0, 0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
